// File: rtl/upd_grad_acc.sv
// Update-stage weight-gradient accumulator: sums (d*h)>>>FRAC over TIMESTEP samples and emits one scaled, saturated gradient per weight.
// Optional build macro GRAD_CLIP_EN clamps the emitted gradient to [-CLIP_VAL, +CLIP_VAL].
module upd_grad_acc #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 12,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 12,
    parameter int TIMESTEP   = 6,
    parameter int NUM_CELL   = 8,
    parameter int NUM_INPUT  = 53,
    parameter int LR_SHIFT   = 0,
    parameter int CLIP_VAL   = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         i_valid,
    input  logic signed [WIDTH-1:0]      i_d,
    input  logic signed [WIDTH-1:0]      i_h,
    output logic                         o_valid,
    output logic signed [WIDTH-1:0]      o_grad,
    output logic        [ADDR_WIDTH-1:0] o_addr_w,
    output logic                         o_done
);

    localparam int TC_W  = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
    localparam int NUM_W = NUM_CELL * NUM_INPUT;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

    logic        [TC_W-1:0]       tcnt_q, tcnt_d;
    logic        [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic signed [ACC_WIDTH-1:0]  p1_q, p1_d;
    logic                         v1_q, v1_d;
    logic                         last1_q, last1_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         o_valid_q, o_valid_d;
    logic                         o_done_q, o_done_d;
    logic signed [WIDTH-1:0]      o_grad_q, o_grad_d;
    logic        [ADDR_WIDTH-1:0] o_addr_w_q, o_addr_w_d;

    logic signed [2*WIDTH-1:0]    prod;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  scaled;
    logic signed [ACC_WIDTH-1:0]  grad_sat;
    logic signed [ACC_WIDTH-1:0]  grad_fin;
    logic                         accept;

    assign accept = en && i_valid;
    assign prod   = i_d * i_h;
    assign sum    = acc_q + p1_q;
    assign scaled = sum >>> LR_SHIFT;

    always_comb begin
        grad_sat = scaled;
        if (scaled > SAT_MAX) begin
            grad_sat = SAT_MAX;
        end else if (scaled < SAT_MIN) begin
            grad_sat = SAT_MIN;
        end
    end

`ifdef GRAD_CLIP_EN
    localparam logic signed [ACC_WIDTH-1:0] CLIP_POS = ACC_WIDTH'(CLIP_VAL);
    localparam logic signed [ACC_WIDTH-1:0] CLIP_NEG = -CLIP_POS;

    always_comb begin
        grad_fin = grad_sat;
        if (grad_sat > CLIP_POS) begin
            grad_fin = CLIP_POS;
        end else if (grad_sat < CLIP_NEG) begin
            grad_fin = CLIP_NEG;
        end
    end
`else
    assign grad_fin = grad_sat;
`endif

    always_comb begin
        tcnt_d     = tcnt_q;
        wcnt_d     = wcnt_q;
        p1_d       = p1_q;
        v1_d       = 1'b0;
        last1_d    = last1_q;
        acc_d      = acc_q;
        o_valid_d  = 1'b0;
        o_done_d   = 1'b0;
        o_grad_d   = o_grad_q;
        o_addr_w_d = o_addr_w_q;

        // Stage 1: scaled product, truncated toward -inf then sized to the accumulator
        if (accept) begin
            p1_d    = ACC_WIDTH'(prod >>> FRAC);
            v1_d    = 1'b1;
            last1_d = (tcnt_q == TC_W'(TIMESTEP - 1));
            tcnt_d  = (tcnt_q == TC_W'(TIMESTEP - 1)) ? '0 : tcnt_q + 1'b1;
        end

        // Stage 2: accumulate, or close the group and restart from zero
        if (v1_q) begin
            if (!last1_q) begin
                acc_d = sum;
            end else begin
                acc_d      = '0;
                o_grad_d   = WIDTH'(grad_fin);
                o_addr_w_d = wcnt_q;
                o_valid_d  = 1'b1;
                if (wcnt_q == ADDR_WIDTH'(NUM_W - 1)) begin
                    wcnt_d   = '0;
                    o_done_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q     <= '0;
            wcnt_q     <= '0;
            p1_q       <= '0;
            v1_q       <= 1'b0;
            last1_q    <= 1'b0;
            acc_q      <= '0;
            o_valid_q  <= 1'b0;
            o_done_q   <= 1'b0;
            o_grad_q   <= '0;
            o_addr_w_q <= '0;
        end else begin
            tcnt_q     <= tcnt_d;
            wcnt_q     <= wcnt_d;
            p1_q       <= p1_d;
            v1_q       <= v1_d;
            last1_q    <= last1_d;
            acc_q      <= acc_d;
            o_valid_q  <= o_valid_d;
            o_done_q   <= o_done_d;
            o_grad_q   <= o_grad_d;
            o_addr_w_q <= o_addr_w_d;
        end
    end

    assign o_valid  = o_valid_q;
    assign o_done   = o_done_q;
    assign o_grad   = o_grad_q;
    assign o_addr_w = o_addr_w_q;

endmodule

// File: tb/tb_upd_grad_acc.sv
// Scoreboard bench for upd_grad_acc: default instance plus an LR_SHIFT=3 instance fed the same stream.
module tb_upd_grad_acc;

    localparam int FRAC     = 12;
    localparam int TIMESTEP = 6;
    localparam int NUM_W    = 8 * 53;
    localparam int CLIP     = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic i_valid = 1'b0;
    logic signed [15:0] i_d = '0;
    logic signed [15:0] i_h = '0;

    logic               o_valid0, o_done0, o_valid1, o_done1;
    logic signed [15:0] o_grad0, o_grad1;
    logic [11:0]        o_addr0, o_addr1;

    upd_grad_acc u_dut (
        .clk(clk), .rst(rst), .en(en), .i_valid(i_valid), .i_d(i_d), .i_h(i_h),
        .o_valid(o_valid0), .o_grad(o_grad0), .o_addr_w(o_addr0), .o_done(o_done0)
    );

    upd_grad_acc #(.LR_SHIFT(3)) u_dut_lr3 (
        .clk(clk), .rst(rst), .en(en), .i_valid(i_valid), .i_d(i_d), .i_h(i_h),
        .o_valid(o_valid1), .o_grad(o_grad1), .o_addr_w(o_addr1), .o_done(o_done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint grad;
        longint addr;
        longint done;
        longint cyc;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    longint part_sum = 0;
    int     part_n = 0;
    int     gidx = 0;

    function automatic longint ref_grad(input longint s, input int sh);
        longint g;
        g = s >>> sh;
        if (g > 32767)  g = 32767;
        if (g < -32768) g = -32768;
`ifdef GRAD_CLIP_EN
        if (g > CLIP)  g = CLIP;
        if (g < -CLIP) g = -CLIP;
`endif
        return g;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: groups of TIMESTEP accepted samples, each a floor-scaled product
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            part_sum = 0;
            part_n   = 0;
            gidx     = 0;
        end else if (en && i_valid) begin
            part_sum = part_sum + ((longint'(i_d) * longint'(i_h)) >>> FRAC);
            part_n   = part_n + 1;
            if (part_n == TIMESTEP) begin
                e.addr = gidx;
                e.done = (gidx == NUM_W - 1) ? 1 : 0;
                e.cyc  = cyc + 1;
                e.grad = ref_grad(part_sum, 0);
                q0.push_back(e);
                e.grad = ref_grad(part_sum, 3);
                q1.push_back(e);
                gidx     = (gidx + 1) % NUM_W;
                part_sum = 0;
                part_n   = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (o_valid0) begin
            if (q0.size() == 0) begin
                check("unexpected_valid", o_valid0, 0);
            end else begin
                e = q0.pop_front();
                check("grad", o_grad0, e.grad);
                check("addr", o_addr0, e.addr);
                check("done", o_done0, e.done);
                check("latency", cyc, e.cyc);
                $display("[TB] grad=%0d addr=%0d done=%0d", o_grad0, o_addr0, o_done0);
            end
        end else if (o_done0) begin
            check("done_without_valid", o_done0, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (o_valid1) begin
            if (q1.size() == 0) begin
                check("unexpected_valid_lr3", o_valid1, 0);
            end else begin
                e = q1.pop_front();
                check("grad_lr3", o_grad1, e.grad);
                check("addr_lr3", o_addr1, e.addr);
                check("done_lr3", o_done1, e.done);
                check("latency_lr3", cyc, e.cyc);
            end
        end else if (o_done1) begin
            check("done_without_valid_lr3", o_done1, 0);
        end
    end

    task automatic drive(input logic signed [15:0] d, input logic signed [15:0] h,
                         input bit v, input bit e);
        @(posedge clk);
        #1;
        i_d     = d;
        i_h     = h;
        i_valid = v;
        en      = e;
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, o_valid0, 0);
        check({tag, "_grad"},  o_grad0,  0);
        check({tag, "_addr"},  o_addr0,  0);
        check({tag, "_done"},  o_done0,  0);
        check({tag, "_valid_lr3"}, o_valid1, 0);
        check({tag, "_grad_lr3"},  o_grad1,  0);
    endtask

    initial begin
        logic signed [15:0] rd, rh;
        // power-on reset
        repeat (2) @(posedge clk);
        reset_check("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // reset in the middle of a group discards the partial sum
        for (int k = 0; k < 3; k++) drive(16'sh1000, 16'sh1000, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_valid = 1'b0;
        @(posedge clk);
        reset_check("mid_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) drive(16'sh1000, 16'sh1000, 1'b1, 1'b1);

        // gaps and en-low cycles between samples
        for (int k = 0; k < 6; k++) begin
            drive(16'sh1000, 16'sh1000, 1'b1, 1'b1);
            if (k % 2 == 1) drive(16'sh7FFF, 16'sh7FFF, 1'b0, 1'b1);
            if (k == 2)     drive(16'sh7FFF, 16'sh7FFF, 1'b1, 1'b0);
        end
        repeat (3) drive(16'sh0000, 16'sh0000, 1'b0, 1'b1);

        // saturation at both rails
        for (int k = 0; k < 6; k++) drive(16'sh7FFF, 16'sh7FFF, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) drive(-16'sh8000, 16'sh7FFF, 1'b1, 1'b1);

        // back-to-back groups of opposite sign
        for (int k = 0; k < 12; k++)
            drive(16'sh1000, (k < 6) ? 16'sh1000 : -16'sh1000, 1'b1, 1'b1);

        // random groups, enough to wrap the full weight pass
        for (int g = 0; g < 430; g++) begin
            for (int s = 0; s < TIMESTEP; s++) begin
                if ($urandom_range(0, 3) == 0) drive(16'sh0000, 16'sh0000, 1'b0, 1'b1);
                if ($urandom_range(0, 7) == 0) drive(16'(($urandom)), 16'(($urandom)), 1'b1, 1'b0);
                case ($urandom_range(0, 3))
                    0:       rd = 16'sh7FFF;
                    1:       rd = -16'sh8000;
                    default: rd = 16'($urandom);
                endcase
                rh = 16'($urandom);
                drive(rd, rh, 1'b1, 1'b1);
            end
        end

        repeat (6) drive(16'sh0000, 16'sh0000, 1'b0, 1'b1);
        check("drain", q0.size(), 0);
        check("drain_lr3", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
